// File: rtl/calc_core.sv
`default_nettype none
// ============================================================================
// Module      : calc_core
// Description : Keypad calculator core. Captures operand A, operand B and the
//               operation on Enter pulses, registers the result and flags, and
//               drives the display value/select path. Supports add, subtract,
//               AND, OR, a soft clear and an optional chain mode.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_core #(
    parameter int WIDTH    = 8,
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enter,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_value,
    input  logic [1:0]       i_op,
    input  logic             i_chain_mode,
    output logic [WIDTH-1:0] o_display,
    output logic             o_show_result,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_carry,
    output logic             o_result_valid,
    output logic [1:0]       o_ledr
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_OR  = 2'b11;
    localparam int         c_MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_A = 2'b00,
        S_B = 2'b01,
        S_R = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_carry;
    logic             r_result_valid;

    // B and the latched Op are only ever consumed on the B-capture edge, so
    // they are folded straight into R and the flags instead of being kept as
    // write-only registers.
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_arith_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_cry;
    logic             w_chain;

    // Subtract is A + ~B + 1, so one adder serves both arithmetic ops.
    assign w_sub       = (i_op == c_OP_SUB);
    assign w_b_eff     = w_sub ? ~i_value : i_value;
    assign w_sum       = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    // Overflow when the effective adder inputs share a sign the sum lacks.
    assign w_arith_ovf = (r_a[c_MSB] == w_b_eff[c_MSB]) && (w_sum[c_MSB] != r_a[c_MSB]);
    assign w_chain     = i_chain_mode && CHAIN_EN;

    // Operation select: next result and flags for the B-capture edge.
    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        w_ovf = 1'b0;
        w_cry = 1'b0;
        case (i_op)
            c_OP_ADD, c_OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_arith_ovf;
                w_cry = w_sum[WIDTH];
            end
            c_OP_AND: w_res = r_a & i_value;
            c_OP_OR:  w_res = r_a | i_value;
            default:  w_res = w_sum[WIDTH-1:0];
        endcase
    end

    // Control FSM and datapath registers; reset and soft clear share one path.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_state        <= S_A;
            r_a            <= '0;
            r_result       <= '0;
            r_overflow     <= 1'b0;
            r_carry        <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (i_enter) begin
                case (r_state)
                    S_A: begin
                        r_a     <= i_value;
                        r_state <= S_B;
                    end
                    S_B: begin
                        r_result       <= w_res;
                        r_overflow     <= w_ovf;
                        r_carry        <= w_cry;
                        r_result_valid <= 1'b1;
                        r_state        <= S_R;
                    end
                    S_R: begin
                        if (w_chain) begin
                            r_a     <= r_result;
                            r_state <= S_B;
                        end else begin
                            r_state <= S_A;
                        end
                    end
                    default: r_state <= S_A;
                endcase
            end
        end
    end

    // Output unit: display mux selected by registered state only.
    assign o_show_result  = (r_state == S_R);
    assign o_display      = o_show_result ? r_result : i_value;
    assign o_result       = r_result;
    assign o_overflow     = r_overflow;
    assign o_carry        = r_carry;
    assign o_result_valid = r_result_valid;
    assign o_ledr         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_core
// Description : Self-checking bench for calc_core (WIDTH=8, CHAIN_EN=1).
//               Table-driven vectors plus hand-written corner sequences;
//               expected results travel through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_core;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] r;
        logic       ov;
        logic       c;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       ov;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] value = 8'h00;
    logic [1:0] op = 2'b00;
    logic       chain = 1'b0;
    logic [7:0] display;
    logic       show_result;
    logic [7:0] result;
    logic       overflow;
    logic       carry;
    logic       result_valid;
    logic [1:0] ledr;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];
    vec_t vecs[9];

    calc_core #(.WIDTH(8), .CHAIN_EN(1'b1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enter        (enter),
        .i_clr          (clr),
        .i_value        (value),
        .i_op           (op),
        .i_chain_mode   (chain),
        .o_display      (display),
        .o_show_result  (show_result),
        .o_result       (result),
        .o_overflow     (overflow),
        .o_carry        (carry),
        .o_result_valid (result_valid),
        .o_ledr         (ledr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_enter(input logic [7:0] v, input logic [1:0] o);
        value = v;
        op    = o;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // Independent reference: signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        exp_t m;
        int sa = $signed(a);
        int sb = $signed(b);
        int ua = a;
        int ub = b;
        int s;
        m.ov = 1'b0;
        m.c  = 1'b0;
        case (o)
            2'b00: begin
                m.r  = a + b;
                m.c  = (ua + ub) > 255;
                s    = sa + sb;
                m.ov = (s > 127) || (s < -128);
            end
            2'b01: begin
                m.r  = a - b;
                m.c  = (ua >= ub);
                s    = sa - sb;
                m.ov = (s > 127) || (s < -128);
            end
            2'b10:   m.r = a & b;
            default: m.r = a | b;
        endcase
        return m;
    endfunction

    // From S_A: capture A (with a decoy Op) then B with the real Op.
    task automatic capture(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o, input exp_t e);
        do_enter(a, ~o);
        sb_q.push_back(e);
        do_enter(b, o);
    endtask

    task automatic check_result(input string name);
        exp_t e;
        int   waited = 0;
        while (!result_valid && waited < 4) begin
            tick();
            waited++;
        end
        if (!result_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no result_valid expected pulse", name);
            void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sb: got result_valid expected none pending", name);
            return;
        end
        e = sb_q.pop_front();
        chk({name, "_result"}, result, e.r);
        chk({name, "_ovf"}, overflow, e.ov);
        chk({name, "_carry"}, carry, e.c);
        chk({name, "_ledr"}, ledr, 2'b10);
        chk({name, "_show"}, show_result, 1'b1);
        chk({name, "_display"}, display, e.r);
        tick();
        chk({name, "_valid_drop"}, result_valid, 1'b0);
    endtask

    task automatic leave_result(input logic [7:0] v);
        chain = 1'b0;
        do_enter(v, 2'b00);
        chk("leave_ledr", ledr, 2'b00);
        chk("leave_valid", result_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0] = '{8'd25,  8'd17,  2'b00, 8'h2A, 1'b0, 1'b0};
        vecs[1] = '{8'd100, 8'd50,  2'b00, 8'h96, 1'b1, 1'b0};
        vecs[2] = '{8'd5,   8'd9,   2'b01, 8'hFC, 1'b0, 1'b0};
        vecs[3] = '{8'd9,   8'd5,   2'b01, 8'h04, 1'b0, 1'b1};
        vecs[4] = '{8'hF0,  8'h3C,  2'b10, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{8'hF0,  8'h3C,  2'b11, 8'hFC, 1'b0, 1'b0};
        vecs[6] = '{8'h7F,  8'h01,  2'b00, 8'h80, 1'b1, 1'b0};
        vecs[7] = '{8'hFF,  8'h01,  2'b00, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{8'h80,  8'h80,  2'b01, 8'h00, 1'b0, 1'b1};

        // Reset state
        value = 8'h3C;
        tick();
        tick();
        chk("rst_ledr", ledr, 2'b00);
        chk("rst_result", result, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_carry", carry, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_show", show_result, 1'b0);
        chk("rst_display", display, 8'h3C);
        rst = 1'b0;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            e.r  = vecs[i].r;
            e.ov = vecs[i].ov;
            e.c  = vecs[i].c;
            capture(vecs[i].a, vecs[i].b, vecs[i].op, e);
            check_result($sformatf("vec%0d", i));
            leave_result(8'h11);
        end

        // Random vectors against the integer model
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [1:0] ro;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ro = 2'($urandom_range(0, 3));
            capture(ra, rb, ro, model(ra, rb, ro));
            check_result($sformatf("rnd%0d", i));
            leave_result(ra);
        end

        // Chain mode: 10+5=15, chain, +3 = 18
        e = '{8'd15, 1'b0, 1'b0};
        capture(8'd10, 8'd5, 2'b00, e);
        check_result("chain_first");
        chain = 1'b1;
        do_enter(8'h77, 2'b00);
        chk("chain_ledr", ledr, 2'b01);
        chk("chain_valid", result_valid, 1'b0);
        chk("chain_display", display, 8'h77);
        chain = 1'b0;
        sb_q.push_back('{8'd18, 1'b0, 1'b0});
        do_enter(8'd3, 2'b00);
        check_result("chain_second");
        do_enter(8'h55, 2'b00);
        chk("nochain_ledr", ledr, 2'b00);
        value = 8'h5A;
        #1;
        chk("nochain_display", display, 8'h5A);

        // Clr with Enter in S_B: Enter discarded, R cleared
        do_enter(8'd1, 2'b00);
        chk("clr_pre_ledr", ledr, 2'b01);
        value = 8'd2;
        clr   = 1'b1;
        enter = 1'b1;
        tick();
        clr   = 1'b0;
        enter = 1'b0;
        chk("clr_ledr", ledr, 2'b00);
        chk("clr_result", result, 8'h00);
        chk("clr_valid", result_valid, 1'b0);
        tick();
        chk("clr_valid_late", result_valid, 1'b0);

        // Reset in S_R after a result with both flags set
        capture(8'h80, 8'h01, 2'b01, model(8'h80, 8'h01, 2'b01));
        check_result("pre_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ledr", ledr, 2'b00);
        chk("midrst_result", result, 8'h00);
        chk("midrst_ovf", overflow, 1'b0);
        chk("midrst_carry", carry, 1'b0);
        chk("midrst_valid", result_valid, 1'b0);
        chk("midrst_show", show_result, 1'b0);
        chk("midrst_display", display, value);

        // Op changes after B capture do not alter R
        capture(8'hF0, 8'h3C, 2'b10, '{8'h30, 1'b0, 1'b0});
        check_result("opchg");
        op = 2'b11;
        tick();
        op = 2'b00;
        tick();
        chk("opchg_result", result, 8'h30);
        chk("opchg_ledr", ledr, 2'b10);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_core.md
Name: calc_core

Overview:
- Parametrised successor to the fixed 8-bit add/subtract calculator sequencing.
- Merges the control FSM and the arithmetic datapath into one block.
- Captures operand A, operand B and the operation from a keypad value stream on synchronised Enter pulses, registers the result and drives the display-select/value path.
- Adds a generic WIDTH, four operations, a soft clear, a result-valid strobe and a chain mode that reuses the result as the next operand A.

Parameters:
- WIDTH, 8, operand/result width in bits; two's complement; minimum 4.
- CHAIN_EN, 1, 1 = ChainMode input honoured; 0 = ChainMode ignored and treated as 0.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; highest priority.
- Enter  input  1  single-cycle pulse, already edge-detected and synchronised upstream.
- Clr  input  1  user soft clear; synchronous, level-sampled.
- Value  input  WIDTH  current keypad entry, two's complement.
- Op  input  2  operation: 00 add, 01 subtract (A-B), 10 AND, 11 OR; sampled on the B-capture Enter.
- ChainMode  input  1  1 = after a result, next Enter loads R into A and goes to B entry.
- Display  output  WIDTH  Value in S_A/S_B; R in S_R.
- ShowResult  output  1  1 only in S_R; mux select for the output unit.
- Result  output  WIDTH  registered result R.
- Overflow  output  1  signed overflow of last add/sub; 0 for logic ops.
- Carry  output  1  adder carry-out of last add/sub (subtract = A + ~B + 1); 0 for logic ops.
- ResultValid  output  1  one-cycle pulse, the cycle after R is registered.
- LEDR  output  2  state code: S_A=00, S_B=01, S_R=10.

Behaviour:
- Reset (any state, any inputs):
  - State = S_A.
  - A, B, R, Overflow, Carry, ResultValid = 0.
  - Display = Value; ShowResult = 0; LEDR = 00.
- Priority when both asserted on the same edge: Reset > Clr > Enter.
- Clr: same effect as Reset, except it is a user input and does not exist upstream. Clr asserted together with Enter means the Enter is discarded.
- FSM, with Enter = 1 on the edge (no change on edges without Enter):
  - S_A: A <= Value; go to S_B.
  - S_B: B <= Value; latch Op into OpReg; R <= f(A, Value, Op); set Overflow/Carry; go to S_R; ResultValid = 1 in the following cycle only.
  - S_R, ChainMode & CHAIN_EN: A <= R; B, R, flags held; go to S_B.
  - S_R, otherwise: go to S_A; A, B, R and flags are held until overwritten.
- Latency: R, Overflow and Carry are visible the cycle after the B-capture edge. Same for Display = R and ShowResult = 1.
- Arithmetic, all WIDTH bits, result truncated to WIDTH (wrap-around):
  - add: {Carry, R} = A + B.
  - sub: {Carry, R} = A + ~B + 1.
  - Overflow (add): operand signs equal and result sign differs.
  - Overflow (sub): A sign differs from B sign and result sign differs from A sign.
- Op changes outside the B-capture edge have no effect. OpReg is internal and not observable except through R.
- Value may change in any cycle. Only the value present on the capturing edge is stored.
- Back-to-back Enter pulses on consecutive cycles are each honoured, one transition per pulse.
- ResultValid never asserts in S_A or on a chain transition.
- Display and ShowResult are combinational from state and registers; no glitch requirement beyond synchronous state.
- All outputs are driven from registers or from a registered-state mux; no combinational path from Enter to any output.

Test Plan (WIDTH=8, CHAIN_EN=1):
- Reset, then Value=25, Enter; Value=17, Op=00, Enter.
  - Result=42 (0x2A), Overflow=0, Carry=0, ResultValid pulses one cycle, LEDR=10, ShowResult=1, Display=42.
- A=100, B=50, add.
  - Result=0x96 (-106), Overflow=1, Carry=0.
- A=5, B=9, Op=01 (subtract).
  - Result=0xFC (-4), Overflow=0, Carry=0.
- Repeat with A=9, B=5: Result=4, Carry=1.
- Chain: A=10, B=5, add gives Result=15. Then ChainMode=1, Enter gives LEDR=01 and internal A=15. Then Value=3, Op=00, Enter gives Result=18. Repeat with ChainMode=0: the Enter after the result gives LEDR=00, and Display follows Value.
- Logic ops: A=0xF0, B=0x3C. Op=10 gives 0x30; Op=11 gives 0xFC. Overflow=0 and Carry=0 in both cases.
- Priority and Op sampling:
  - In S_B, assert Clr and Enter on the same edge: next cycle LEDR=00, Result=0, no ResultValid.
  - Repeat with Reset mid-S_R: all outputs return to reset values.
  - Change Op after B-capture: Result unchanged.
